// File: rtl/bcd_digit_scan_decoder.sv
// Serialises a packed BCD word into one 10-bit one-hot beat per digit; first beat valid the cycle after accept.
// Backpressure: all out_* hold while out_ready is low; in_ready is high only while idle (no overlap).
module bcd_digit_scan_decoder #(
  parameter int NUM_DIGITS         = 4,
  parameter bit MSD_FIRST          = 1'b0,
  parameter bit SKIP_LEADING_ZEROS = 1'b0,
  localparam int IDXW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [4*NUM_DIGITS-1:0] in_bcd,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [9:0]              out_onehot,
  output logic [IDXW-1:0]         out_idx,
  output logic                    out_last,
  output logic                    out_err,
  output logic                    word_err
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SCAN = 1'b1;
  localparam logic [IDXW-1:0] MAX_IDX = IDXW'(NUM_DIGITS - 1);
  localparam logic [IDXW-1:0] ONE_IDX = IDXW'(1);

  logic [0:0]              state;
  logic [4*NUM_DIGITS-1:0] bcd_q;
  logic [IDXW-1:0]         idx_q;
  logic [IDXW-1:0]         end_hi_q;
  logic                    word_err_q;

  logic [IDXW-1:0] in_top;
  logic [IDXW-1:0] in_end_hi;
  logic            in_any_err;
  logic [3:0]      cur_digit;
  logic [9:0]      cur_onehot;
  logic            cur_last;

  // A nibble >9 counts as nonzero, so an invalid digit is never suppressed.
  always_comb begin
    in_top     = '0;
    in_any_err = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (in_bcd[4*k +: 4] != 4'd0) in_top = IDXW'(k);
      if (in_bcd[4*k +: 4] > 4'd9)  in_any_err = 1'b1;
    end
    in_end_hi = SKIP_LEADING_ZEROS ? in_top : MAX_IDX;
  end

  always_comb begin
    cur_digit = 4'd0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IDXW'(k)) cur_digit = bcd_q[4*k +: 4];
    end
    cur_onehot = (cur_digit <= 4'd9) ? (10'd1 << cur_digit) : 10'd0;
    cur_last   = (idx_q == (MSD_FIRST ? {IDXW{1'b0}} : end_hi_q));
  end

  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == SCAN);
  assign out_onehot = out_valid ? cur_onehot : 10'd0;
  assign out_idx    = out_valid ? idx_q : {IDXW{1'b0}};
  assign out_last   = out_valid & cur_last;
  assign out_err    = out_valid & (cur_digit > 4'd9);
  assign word_err   = out_valid & word_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bcd_q      <= '0;
      idx_q      <= '0;
      end_hi_q   <= '0;
      word_err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state      <= SCAN;
            bcd_q      <= in_bcd;
            end_hi_q   <= in_end_hi;
            idx_q      <= MSD_FIRST ? in_end_hi : {IDXW{1'b0}};
            word_err_q <= in_any_err;
          end
        end
        SCAN: begin
          if (out_ready) begin
            if (cur_last)       state <= IDLE;
            else if (MSD_FIRST) idx_q <= idx_q - ONE_IDX;
            else                idx_q <= idx_q + ONE_IDX;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_digit_scan_decoder.sv
// Bench for bcd_digit_scan_decoder: LSD-first instance (a) and MSD-first/zero-skipping instance (b).
module tb_bcd_digit_scan_decoder;

  typedef struct packed {
    logic [1:0] idx;
    logic [9:0] oh;
    logic       last;
    logic       err;
    logic       werr;
  } beat_t;

  typedef struct packed {
    logic            sel;
    logic [15:0]     bcd;
    logic [2:0]      n;
    logic [3:0][1:0] idx;
    logic [3:0][9:0] oh;
    logic [3:0]      err;
    logic            werr;
  } vec_t;

  localparam int NV = 12;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_bcd;
  logic        in_valid_a, in_valid_b, in_ready_a, in_ready_b;
  logic        out_valid_a, out_valid_b, rdy_a, rdy_b;
  logic [9:0]  out_onehot_a, out_onehot_b;
  logic [1:0]  out_idx_a, out_idx_b;
  logic        out_last_a, out_last_b, out_err_a, out_err_b, word_err_a, word_err_b;
  logic        rand_rdy;

  int    errors = 0;
  int    checks = 0;
  beat_t q_a[$];
  beat_t q_b[$];
  beat_t exp_a, exp_b, act_a, act_b;
  vec_t  vecs[NV];

  always #5 clk = ~clk;

  bcd_digit_scan_decoder #(.NUM_DIGITS(4), .MSD_FIRST(1'b0), .SKIP_LEADING_ZEROS(1'b0)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a), .in_bcd(in_bcd),
    .out_valid(out_valid_a), .out_ready(rdy_a), .out_onehot(out_onehot_a), .out_idx(out_idx_a),
    .out_last(out_last_a), .out_err(out_err_a), .word_err(word_err_a));

  bcd_digit_scan_decoder #(.NUM_DIGITS(4), .MSD_FIRST(1'b1), .SKIP_LEADING_ZEROS(1'b1)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b), .in_bcd(in_bcd),
    .out_valid(out_valid_b), .out_ready(rdy_b), .out_onehot(out_onehot_b), .out_idx(out_idx_b),
    .out_last(out_last_b), .out_err(out_err_b), .word_err(word_err_b));

  function automatic vec_t mk(input logic sel, input logic [15:0] bcd, input int n,
                              input logic [1:0] i0, i1, i2, i3,
                              input logic [9:0] o0, o1, o2, o3,
                              input logic [3:0] err, input logic werr);
    vec_t v;
    v.sel = sel; v.bcd = bcd; v.n = 3'(n);
    v.idx[0] = i0; v.idx[1] = i1; v.idx[2] = i2; v.idx[3] = i3;
    v.oh[0] = o0;  v.oh[1] = o1;  v.oh[2] = o2;  v.oh[3] = o3;
    v.err = err; v.werr = werr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard pops one expected beat per accepted output handshake.
  always @(negedge clk) begin
    if (!rst && out_valid_a && rdy_a) begin
      act_a = '{idx: out_idx_a, oh: out_onehot_a, last: out_last_a, err: out_err_a, werr: word_err_a};
      checks++;
      if (q_a.size() == 0) begin
        errors++;
        $display("FAIL beat_a unexpected: got %h expected none", act_a);
      end else begin
        exp_a = q_a.pop_front();
        if (act_a !== exp_a) begin
          errors++;
          $display("FAIL beat_a: got %h expected %h", act_a, exp_a);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid_b && rdy_b) begin
      act_b = '{idx: out_idx_b, oh: out_onehot_b, last: out_last_b, err: out_err_b, werr: word_err_b};
      checks++;
      if (q_b.size() == 0) begin
        errors++;
        $display("FAIL beat_b unexpected: got %h expected none", act_b);
      end else begin
        exp_b = q_b.pop_front();
        if (act_b !== exp_b) begin
          errors++;
          $display("FAIL beat_b: got %h expected %h", act_b, exp_b);
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) begin
        rdy_a = 1'($urandom_range(0, 1));
        rdy_b = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic send_vec(input vec_t v);
    int    n = 0;
    beat_t b;
    while (!(v.sel ? in_ready_b : in_ready_a) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
    for (int k = 0; k < int'(v.n); k++) begin
      b = '{idx: v.idx[k], oh: v.oh[k], last: (k == int'(v.n) - 1), err: v.err[k], werr: v.werr};
      if (v.sel) q_b.push_back(b);
      else       q_a.push_back(b);
    end
    in_bcd = v.bcd;
    if (v.sel) in_valid_b = 1'b1;
    else       in_valid_a = 1'b1;
    @(posedge clk); #1;
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
    chk("first_beat_latency", v.sel ? out_valid_b : out_valid_a, 1);
  endtask

  task automatic drain(input bit sel);
    int n = 0;
    while (((sel ? q_b.size() : q_a.size()) != 0) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk("drain_done", (n < 200) ? 1 : 0, 1);
  endtask

  initial begin
    int cnt;
    vecs[0]  = mk(0, 16'h1937, 4, 0, 1, 2, 3, 10'h080, 10'h008, 10'h200, 10'h002, 4'b0000, 0);
    vecs[1]  = mk(0, 16'h0A05, 4, 0, 1, 2, 3, 10'h020, 10'h001, 10'h000, 10'h001, 4'b0100, 1);
    vecs[2]  = mk(0, 16'h0000, 4, 0, 1, 2, 3, 10'h001, 10'h001, 10'h001, 10'h001, 4'b0000, 0);
    vecs[3]  = mk(0, 16'h8642, 4, 0, 1, 2, 3, 10'h004, 10'h010, 10'h040, 10'h100, 4'b0000, 0);
    vecs[4]  = mk(0, 16'hF9E0, 4, 0, 1, 2, 3, 10'h001, 10'h000, 10'h200, 10'h000, 4'b1010, 1);
    vecs[5]  = mk(0, 16'h5555, 4, 0, 1, 2, 3, 10'h020, 10'h020, 10'h020, 10'h020, 4'b0000, 0);
    vecs[6]  = mk(1, 16'h0042, 2, 1, 0, 0, 0, 10'h010, 10'h004, 10'h000, 10'h000, 4'b0000, 0);
    vecs[7]  = mk(1, 16'h0000, 1, 0, 0, 0, 0, 10'h001, 10'h000, 10'h000, 10'h000, 4'b0000, 0);
    vecs[8]  = mk(1, 16'h1937, 4, 3, 2, 1, 0, 10'h002, 10'h200, 10'h008, 10'h080, 4'b0000, 0);
    vecs[9]  = mk(1, 16'h0A05, 3, 2, 1, 0, 0, 10'h000, 10'h001, 10'h020, 10'h000, 4'b0001, 1);
    vecs[10] = mk(1, 16'h00F0, 2, 1, 0, 0, 0, 10'h000, 10'h001, 10'h000, 10'h000, 4'b0001, 1);
    vecs[11] = mk(1, 16'h0900, 3, 2, 1, 0, 0, 10'h200, 10'h001, 10'h001, 10'h000, 4'b0000, 0);

    rst = 1'b1; in_valid_a = 1'b1; in_valid_b = 1'b1; in_bcd = 16'h1234;
    rdy_a = 1'b1; rdy_b = 1'b1; rand_rdy = 1'b0;

    // Reset held for two edges with in_valid asserted: nothing may be captured.
    @(posedge clk); #1;
    chk("rst_out_valid_a", out_valid_a, 0);
    chk("rst_out_valid_b", out_valid_b, 0);
    @(negedge clk);
    chk("rst_onehot", out_onehot_a, 0);
    chk("rst_idx", out_idx_a, 0);
    chk("rst_last", out_last_a, 0);
    chk("rst_err", out_err_a, 0);
    chk("rst_word_err", word_err_a, 0);
    chk("rst_out_valid_a2", out_valid_a, 0);
    @(posedge clk); #1;
    rst = 1'b0; in_valid_a = 1'b0; in_valid_b = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready_a", in_ready_a, 1);
    chk("post_rst_in_ready_b", in_ready_b, 1);
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_no_beat", out_valid_a | out_valid_b, 0);
    end
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      send_vec(vecs[i]);
      cnt = 0;
      @(negedge clk);
      while (!(vecs[i].sel ? in_ready_b : in_ready_a) && cnt < 50) begin
        cnt++;
        @(negedge clk);
      end
      chk("in_ready_low_cycles", cnt, 32'(vecs[i].n));
      chk("sb_empty", vecs[i].sel ? q_b.size() : q_a.size(), 0);
      @(posedge clk); #1;
    end

    rand_rdy = 1'b1;
    for (int i = 0; i < NV; i++) begin
      send_vec(vecs[i]);
      drain(vecs[i].sel);
    end
    rand_rdy = 1'b0;
    @(posedge clk); #1;
    rdy_a = 1'b1; rdy_b = 1'b1;
    drain(1'b0);
    drain(1'b1);
    repeat (2) begin @(posedge clk); #1; end

    // Stall on the idx1 beat for three cycles.
    rdy_a = 1'b0;
    send_vec(vecs[0]);
    rdy_a = 1'b1;
    @(posedge clk); #1;
    rdy_a = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_valid", out_valid_a, 1);
      chk("stall_idx", out_idx_a, 1);
      chk("stall_onehot", out_onehot_a, 10'h008);
      chk("stall_last", out_last_a, 0);
    end
    @(posedge clk); #1;
    rdy_a = 1'b1;
    drain(1'b0);
    @(posedge clk); #1;

    // Reset while the idx2 beat is presented; the rest of that word must vanish.
    send_vec(vecs[0]);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_idx", out_idx_a, 2);
    rst = 1'b1; rdy_a = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_out_valid", out_valid_a, 0);
    chk("mid_rst_in_ready", in_ready_a, 1);
    chk("mid_rst_pending", q_a.size(), 2);
    q_a.delete();
    rdy_a = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("mid_rst_no_beat", out_valid_a, 0);
    end
    @(posedge clk); #1;
    send_vec(mk(0, 16'h0001, 4, 0, 1, 2, 3, 10'h002, 10'h001, 10'h001, 10'h001, 4'b0000, 0));
    drain(1'b0);
    repeat (2) begin @(posedge clk); #1; end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
